// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the A-RISC program loader: the loader state
// encoding, frame header offsets and the A-RISC opcode constants. The loader,
// its stream interface, the CPU and the bench all import this package.
// -----------------------------------------------------------------------------
package prog_loader_pkg;

  typedef logic [7:0] byte_t;

  // Loader FSM states, encoded in 4 bits.
  typedef enum logic [3:0] {
    S_HDR_NI = 4'd0,
    S_HDR_ND = 4'd1,
    S_HDR_NO = 4'd2,
    S_INS_LO = 4'd3,
    S_INS_HI = 4'd4,
    S_DATA   = 4'd5,
    S_START  = 4'd6,
    S_RUN    = 4'd7,
    S_READ   = 4'd8,
    S_SEND   = 4'd9
  } state_t;

  // Byte offsets of the header fields within a frame.
  localparam int OFF_NI  = 0;
  localparam int OFF_ND  = 1;
  localparam int OFF_NO  = 2;
  localparam int HDR_LEN = 3;

  // A-RISC opcodes (low byte of an IRAM word).
  localparam byte_t I_END = 8'h00;
  localparam byte_t I_LDA = 8'h01;
  localparam byte_t I_STA = 8'h02;
  localparam byte_t I_ADD = 8'h03;
  localparam byte_t I_SUB = 8'h04;
  localparam byte_t I_JMP = 8'h05;
  localparam byte_t I_JMZ = 8'h06;
  localparam byte_t I_JMN = 8'h07;

  // Where the loader goes once the instruction section is finished (or
  // skipped): the data section if there is one, otherwise straight to start.
  function automatic state_t afterInstr(input byte_t nd);
    return (nd != 8'd0) ? S_DATA : S_START;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// -----------------------------------------------------------------------------
// prog_loader_if
// Byte-stream handshake bundle of the loader.
//   s_data/s_valid/s_ready : inbound frame bytes (host -> loader)
//   m_data/m_valid/m_ready : outbound DRAM readback bytes (loader -> host)
// Modports:
//   slave  : the loader side
//   master : the host / testbench side
// -----------------------------------------------------------------------------
interface prog_loader_if;
  import prog_loader_pkg::*;

  byte_t s_data;
  logic  s_valid;
  logic  s_ready;
  byte_t m_data;
  logic  m_valid;
  logic  m_ready;

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid
  );

endinterface

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Byte-stream front end for the A-RISC core. Accepts a frame
//   NI, ND, NO, NI x {opc, opr}, ND x data
// writes the instructions to IRAM and the data bytes to DRAM, pulses the CPU
// start, waits for the CPU to become idle again and streams DRAM[0..NO-1] back.
// Ports:
//   clk, rstn      : clock, asynchronous active-low reset
//   strm           : inbound/outbound byte streams (prog_loader_if.slave)
//   cpu_start      : one-cycle start pulse to the CPU
//   cpu_idle       : CPU idle status
//   ram_sel        : 1 = loader owns the RAM ports, 0 = CPU owns them
//   iram_*         : IRAM write port (word = {opr, opc})
//   dram_*         : DRAM read/write port (registered read, RD_LAT cycles)
//   run_cycles     : saturating cycle count of the last CPU run
//   busy           : high whenever the loader is not waiting for a new frame
// -----------------------------------------------------------------------------
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int W_CYC  = 16,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rstn,
  prog_loader_if.slave     strm,
  output logic             cpu_start,
  input  logic             cpu_idle,
  output logic             ram_sel,
  output logic [7:0]       iram_addr,
  output logic [15:0]      iram_din,
  output logic             iram_write,
  output logic [7:0]       dram_addr,
  output logic [7:0]       dram_din,
  input  logic [7:0]       dram_dout,
  output logic             dram_write,
  output logic [W_CYC-1:0] run_cycles,
  output logic             busy
);

  // RD_LAT is only legal as 1 or 2, so two bits hold the wait count.
  localparam logic [1:0] C_LAT = 2'(RD_LAT);

  state_t           r_state;
  byte_t            r_ni;
  byte_t            r_nd;
  byte_t            r_no;
  byte_t            r_opc;
  byte_t            r_k;
  byte_t            r_j;
  byte_t            r_r;
  logic [1:0]       r_lat;
  byte_t            r_mData;
  logic             r_mValid;
  logic [W_CYC-1:0] r_cyc;

  logic w_accept;
  logic w_insWr;
  logic w_datWr;
  logic w_readPhase;

  // The loader only listens to the inbound stream while collecting a frame.
  assign strm.s_ready = (r_state == S_HDR_NI) || (r_state == S_HDR_ND) ||
                        (r_state == S_HDR_NO) || (r_state == S_INS_LO) ||
                        (r_state == S_INS_HI) || (r_state == S_DATA);

  assign w_accept    = strm.s_valid && strm.s_ready;
  assign w_insWr     = w_accept && (r_state == S_INS_HI);
  assign w_datWr     = w_accept && (r_state == S_DATA);
  assign w_readPhase = (r_state == S_READ) || (r_state == S_SEND);

  // Write strobes follow the handshake in the same cycle so the RAMs take one
  // word per accepted high byte and one data byte per accepted byte.
  assign iram_write = w_insWr;
  assign iram_addr  = r_k;
  assign iram_din   = w_insWr ? {strm.s_data, r_opc} : 16'h0000;
  assign dram_write = w_datWr;
  assign dram_addr  = w_readPhase ? r_r : r_j;
  assign dram_din   = w_datWr ? strm.s_data : 8'h00;

  // Status outputs are decodes of the state register, so a reset takes them
  // straight to their idle values without waiting for a clock.
  assign cpu_start    = (r_state == S_START);
  assign ram_sel      = !((r_state == S_START) || (r_state == S_RUN));
  assign busy         = (r_state != S_HDR_NI);
  assign run_cycles   = r_cyc;
  assign strm.m_data  = r_mData;
  assign strm.m_valid = r_mValid;

  // Single frame/run/readback sequencer. Counters k (instructions), j (data)
  // and r (readback) are cleared while waiting for a header. In S_READ the
  // address is held for RD_LAT cycles before the RAM output is captured into
  // the readback register, which then stays put until the sink takes it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_HDR_NI;
      r_ni     <= '0;
      r_nd     <= '0;
      r_no     <= '0;
      r_opc    <= '0;
      r_k      <= '0;
      r_j      <= '0;
      r_r      <= '0;
      r_lat    <= '0;
      r_mData  <= '0;
      r_mValid <= 1'b0;
      r_cyc    <= '0;
    end else begin
      case (r_state)
        S_HDR_NI: begin
          r_k <= '0;
          r_j <= '0;
          r_r <= '0;
          if (w_accept) begin
            r_ni    <= strm.s_data;
            r_state <= S_HDR_ND;
          end
        end
        S_HDR_ND: begin
          if (w_accept) begin
            r_nd    <= strm.s_data;
            r_state <= S_HDR_NO;
          end
        end
        S_HDR_NO: begin
          if (w_accept) begin
            r_no    <= strm.s_data;
            r_state <= (r_ni != 8'd0) ? S_INS_LO : afterInstr(r_nd);
          end
        end
        S_INS_LO: begin
          if (w_accept) begin
            r_opc   <= strm.s_data;
            r_state <= S_INS_HI;
          end
        end
        S_INS_HI: begin
          if (w_accept) begin
            r_k     <= r_k + 8'd1;
            r_state <= (r_k == r_ni - 8'd1) ? afterInstr(r_nd) : S_INS_LO;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_j <= r_j + 8'd1;
            if (r_j == r_nd - 8'd1) begin
              r_state <= S_START;
            end
          end
        end
        S_START: begin
          r_cyc   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (r_cyc != '1) begin
            r_cyc <= r_cyc + W_CYC'(1);
          end
          if (cpu_idle) begin
            r_lat   <= '0;
            r_state <= (r_no != 8'd0) ? S_READ : S_HDR_NI;
          end
        end
        S_READ: begin
          if (r_lat == C_LAT) begin
            r_mData  <= dram_dout;
            r_mValid <= 1'b1;
            r_state  <= S_SEND;
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end
        S_SEND: begin
          if (strm.m_ready) begin
            r_mValid <= 1'b0;
            r_r      <= r_r + 8'd1;
            r_lat    <= '0;
            r_state  <= (r_r == r_no - 8'd1) ? S_HDR_NI : S_READ;
          end
        end
        default: begin
          r_state <= S_HDR_NI;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
// Self-checking bench for prog_loader. Frames are described in a table of
// stimulus/expectation records; the bench holds behavioural IRAM/DRAM models
// (registered read, RD_LAT stages) and a CPU model that drops idle on start
// and stays busy for a configurable number of cycles.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  localparam int W_CYC    = 16;
  localparam int RD_LAT   = 2;
  localparam int WAIT_MAX = 80000;

  typedef struct {
    logic [7:0]        ni;
    logic [7:0]        nd;
    logic [7:0]        no;
    logic [0:7][7:0]   payload;
    int                cpuLen;
    logic [15:0]       expRun;
    logic [0:1][15:0]  expIram;
    logic [0:2][7:0]   expDram;
    logic [0:2][7:0]   expRead;
    bit                gaps;
    int                stall;
  } frameVec_t;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             cpuStart;
  logic             cpuIdle;
  logic             ramSel;
  logic [7:0]       iramAddr;
  logic [15:0]      iramDin;
  logic             iramWrite;
  logic [7:0]       dramAddr;
  logic [7:0]       dramDin;
  logic [7:0]       dramDout;
  logic             dramWrite;
  logic [W_CYC-1:0] runCycles;
  logic             busy;

  prog_loader_if bus ();

  always #5 clk = ~clk;

  prog_loader #(.W_CYC(W_CYC), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .strm       (bus),
    .cpu_start  (cpuStart),
    .cpu_idle   (cpuIdle),
    .ram_sel    (ramSel),
    .iram_addr  (iramAddr),
    .iram_din   (iramDin),
    .iram_write (iramWrite),
    .dram_addr  (dramAddr),
    .dram_din   (dramDin),
    .dram_dout  (dramDout),
    .dram_write (dramWrite),
    .run_cycles (runCycles),
    .busy       (busy)
  );

  logic [15:0] iram [256];
  logic [7:0]  dram [256];
  logic [7:0]  rdPipe1;
  logic [7:0]  rdPipe2;
  logic        clearReq = 1'b0;
  int          cpuLenCfg = 1;
  int          iramWrCnt;
  int          dramWrCnt;
  int          startCnt;
  int          runReadyCnt;
  int          unstableCnt;
  logic        holdPrev;
  logic [7:0]  holdData;
  int          cpuCnt;
  int          nVec;
  int          nMis;
  frameVec_t   vecs [6];

  // RAM models plus event counters; clearReq scrubs both RAMs to all-ones
  // and zeroes the counters so each frame is judged on its own.
  always @(posedge clk) begin
    if (clearReq) begin
      for (int i = 0; i < 256; i++) begin
        iram[i] <= 16'hFFFF;
        dram[i] <= 8'hFF;
      end
      iramWrCnt   <= 0;
      dramWrCnt   <= 0;
      startCnt    <= 0;
      runReadyCnt <= 0;
      unstableCnt <= 0;
    end else begin
      if (ramSel && iramWrite) begin
        iram[iramAddr] <= iramDin;
        iramWrCnt      <= iramWrCnt + 1;
      end
      if (ramSel && dramWrite) begin
        dram[dramAddr] <= dramDin;
        dramWrCnt      <= dramWrCnt + 1;
      end
      if (cpuStart) startCnt <= startCnt + 1;
      if (!ramSel && bus.s_ready) runReadyCnt <= runReadyCnt + 1;
      if (holdPrev && (bus.m_data != holdData || !bus.m_valid))
        unstableCnt <= unstableCnt + 1;
    end
    rdPipe1 <= dram[dramAddr];
    rdPipe2 <= rdPipe1;
  end

  assign dramDout = (RD_LAT == 2) ? rdPipe2 : rdPipe1;

  // Remembers whether the readback byte was stalled last cycle so its
  // stability can be checked on the next edge.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      holdPrev <= 1'b0;
      holdData <= 8'h00;
    end else begin
      holdPrev <= bus.m_valid && !bus.m_ready;
      holdData <= bus.m_data;
    end
  end

  // CPU model: leaves idle on the edge that samples start, runs cpuLenCfg
  // cycles, then reports idle again. Shares the loader reset.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cpuIdle <= 1'b1;
      cpuCnt  <= 0;
    end else if (cpuStart) begin
      cpuIdle <= 1'b0;
      cpuCnt  <= cpuLenCfg - 1;
    end else if (!cpuIdle) begin
      if (cpuCnt == 0) cpuIdle <= 1'b1;
      else cpuCnt <= cpuCnt - 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Offers one byte at a negedge and holds it until accepted.
  task automatic sendByte(input logic [7:0] b, input bit gaps);
    int bud;
    if (gaps) begin
      bus.s_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    bud = 0;
    while (!bus.s_ready && bud < 1000) begin
      @(negedge clk);
      bud++;
    end
    if (!bus.s_ready) begin
      checkOutput("s_ready timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
  endtask

  function automatic frameVec_t mkVec(
    input logic [7:0] ni, input logic [7:0] nd, input logic [7:0] no,
    input logic [0:7][7:0] pl, input int cpuLen, input logic [15:0] expRun,
    input logic [0:1][15:0] ei, input logic [0:2][7:0] ed,
    input logic [0:2][7:0] er, input bit gaps, input int stall);
    frameVec_t v;
    v.ni = ni; v.nd = nd; v.no = no; v.payload = pl;
    v.cpuLen = cpuLen; v.expRun = expRun; v.expIram = ei;
    v.expDram = ed; v.expRead = er; v.gaps = gaps; v.stall = stall;
    return v;
  endfunction

  // Loads one frame, lets the CPU model run, collects the readback and
  // compares images, counts and readback bytes against the record.
  task automatic applyStimulus(input frameVec_t v, input int tag);
    logic [7:0]      fb [16];
    logic [0:2][7:0] got;
    int              n;
    int              bud;
    bit              timedOut;
    cpuLenCfg = v.cpuLen;
    clearReq  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clearReq  = 1'b0;
    fb[0] = v.ni;
    fb[1] = v.nd;
    fb[2] = v.no;
    n = 3 + 2 * int'(v.ni) + int'(v.nd);
    for (int i = 0; i < n - 3; i++) fb[3 + i] = v.payload[i];
    for (int i = 0; i < n; i++) sendByte(fb[i], v.gaps);
    got = '0;
    timedOut = 1'b0;
    for (int b = 0; b < int'(v.no) && !timedOut; b++) begin
      bus.m_ready = (v.stall == 0);
      bud = 0;
      while (!bus.m_valid && bud < WAIT_MAX) begin
        @(negedge clk);
        bud++;
      end
      if (!bus.m_valid) begin
        checkOutput($sformatf("v%0d readback timeout", tag), 32'd0, 32'd1);
        timedOut = 1'b1;
      end else begin
        repeat (v.stall) @(negedge clk);
        bus.m_ready = 1'b1;
        got[b] = bus.m_data;
        @(posedge clk);
        @(negedge clk);
      end
    end
    bus.m_ready = 1'b0;
    bud = 0;
    while (busy && bud < WAIT_MAX) begin
      @(negedge clk);
      bud++;
    end
    checkOutput($sformatf("v%0d back to idle", tag), 32'(busy), 32'd0);
    checkOutput($sformatf("v%0d m_valid after", tag), 32'(bus.m_valid), 32'd0);
    checkOutput($sformatf("v%0d start pulses", tag), 32'(startCnt), 32'd1);
    checkOutput($sformatf("v%0d iram writes", tag), 32'(iramWrCnt), 32'(v.ni));
    checkOutput($sformatf("v%0d dram writes", tag), 32'(dramWrCnt), 32'(v.nd));
    checkOutput($sformatf("v%0d run_cycles", tag), 32'(runCycles), 32'(v.expRun));
    checkOutput($sformatf("v%0d s_ready in run", tag), 32'(runReadyCnt), 32'd0);
    checkOutput($sformatf("v%0d m_data stable", tag), 32'(unstableCnt), 32'd0);
    for (int k = 0; k < int'(v.ni); k++)
      checkOutput($sformatf("v%0d iram[%0d]", tag, k), 32'(iram[k]), 32'(v.expIram[k]));
    checkOutput($sformatf("v%0d iram past NI", tag), 32'(iram[v.ni]), 32'hFFFF);
    for (int j = 0; j < int'(v.nd); j++)
      checkOutput($sformatf("v%0d dram[%0d]", tag, j), 32'(dram[j]), 32'(v.expDram[j]));
    checkOutput($sformatf("v%0d dram past ND", tag), 32'(dram[v.nd]), 32'hFF);
    for (int b = 0; b < int'(v.no); b++)
      checkOutput($sformatf("v%0d readback[%0d]", tag, b), 32'(got[b]), 32'(v.expRead[b]));
  endtask

  initial begin
    #1500000;
    nMis++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    int bud;
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    nVec = 0;
    nMis = 0;

    vecs[0] = mkVec(8'd2, 8'd0, 8'd0, {8'h06, 8'h05, 8'h00, 8'h00, 32'h0}, 3, 16'd4,
                    {16'h0506, 16'h0000}, 24'h0, 24'h0, 1'b0, 0);
    vecs[1] = mkVec(8'd0, 8'd3, 8'd2, {8'hAA, 8'hBB, 8'hCC, 40'h0}, 1, 16'd2,
                    32'h0, {8'hAA, 8'hBB, 8'hCC}, {8'hAA, 8'hBB, 8'h00}, 1'b0, 0);
    vecs[2] = mkVec(8'd1, 8'd2, 8'd2, {8'h34, 8'h12, 8'h5A, 8'hA5, 32'h0}, 5, 16'd6,
                    {16'h1234, 16'h0000}, {8'h5A, 8'hA5, 8'h00}, {8'h5A, 8'hA5, 8'h00}, 1'b0, 0);
    vecs[3] = mkVec(8'd0, 8'd0, 8'd0, 64'h0, 2, 16'd3, 32'h0, 24'h0, 24'h0, 1'b0, 0);
    vecs[4] = mkVec(8'd1, 8'd2, 8'd2, {8'h34, 8'h12, 8'h5A, 8'hA5, 32'h0}, 5, 16'd6,
                    {16'h1234, 16'h0000}, {8'h5A, 8'hA5, 8'h00}, {8'h5A, 8'hA5, 8'h00}, 1'b1, 5);
    vecs[5] = mkVec(8'd0, 8'd2, 8'd2, {8'h3C, 8'hC3, 48'h0}, 70000, 16'hFFFF,
                    32'h0, {8'h3C, 8'hC3, 8'h00}, {8'h3C, 8'hC3, 8'h00}, 1'b0, 0);

    #3;
    checkOutput("reset s_ready", 32'(bus.s_ready), 32'd1);
    checkOutput("reset m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("reset m_data", 32'(bus.m_data), 32'd0);
    checkOutput("reset cpu_start", 32'(cpuStart), 32'd0);
    checkOutput("reset ram_sel", 32'(ramSel), 32'd1);
    checkOutput("reset iram_write", 32'(iramWrite), 32'd0);
    checkOutput("reset dram_write", 32'(dramWrite), 32'd0);
    checkOutput("reset iram_addr", 32'(iramAddr), 32'd0);
    checkOutput("reset iram_din", 32'(iramDin), 32'd0);
    checkOutput("reset dram_addr", 32'(dramAddr), 32'd0);
    checkOutput("reset dram_din", 32'(dramDin), 32'd0);
    checkOutput("reset run_cycles", 32'(runCycles), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

    // Reset while in the data section: header 00,03,01 and one data byte.
    $display("[TB] reset during S_DATA");
    cpuLenCfg = 1;
    sendByte(8'h00, 1'b0);
    sendByte(8'h03, 1'b0);
    sendByte(8'h01, 1'b0);
    sendByte(8'h11, 1'b0);
    bus.s_data  = 8'h77;
    bus.s_valid = 1'b1;
    #1;
    checkOutput("S_DATA write strobe", 32'(dramWrite), 32'd1);
    checkOutput("S_DATA address", 32'(dramAddr), 32'd1);
    checkOutput("S_DATA din", 32'(dramDin), 32'h77);
    #1 rstn = 1'b0;
    #1;
    checkOutput("rst data dram_write", 32'(dramWrite), 32'd0);
    checkOutput("rst data dram_addr", 32'(dramAddr), 32'd0);
    checkOutput("rst data busy", 32'(busy), 32'd0);
    checkOutput("rst data s_ready", 32'(bus.s_ready), 32'd1);
    checkOutput("rst data ram_sel", 32'(ramSel), 32'd1);
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus(vecs[1], 11);

    // Reset while the CPU runs: frame 00,00,00 with a long CPU program.
    $display("[TB] reset during S_RUN");
    cpuLenCfg = 50;
    sendByte(8'h00, 1'b0);
    sendByte(8'h00, 1'b0);
    sendByte(8'h00, 1'b0);
    bud = 0;
    while (ramSel && bud < 100) begin
      @(negedge clk);
      bud++;
    end
    checkOutput("run ram_sel low", 32'(ramSel), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("run s_ready low", 32'(bus.s_ready), 32'd0);
    checkOutput("run cycles mid-run", 32'(runCycles), 32'd4);
    checkOutput("run cpu_start done", 32'(cpuStart), 32'd0);
    #2 rstn = 1'b0;
    #1;
    checkOutput("rst run ram_sel", 32'(ramSel), 32'd1);
    checkOutput("rst run run_cycles", 32'(runCycles), 32'd0);
    checkOutput("rst run busy", 32'(busy), 32'd0);
    checkOutput("rst run cpu_start", 32'(cpuStart), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus(vecs[0], 10);

    $display("[TB] long run, run_cycles saturation");
    applyStimulus(vecs[5], 5);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
